rob_mc: RTL and testbench
=========================

# rob_mc

Parametrised multi-commit reorder buffer between decoder/RS issue and architectural state. Allocates entries in program order, accepts out-of-order results on multiple writeback ports, and retires up to COMMIT_W ready entries per cycle in order. Drives register-file writes, LSB store release, RS dependency updates and the front-end redirect/flush on a taken jump.

## Interface
- ROB_WIDTH, 4: tag width; depth = 2**ROB_WIDTH (all entries usable).
- RS_WIDTH, 2: RS slot index width.
- COMMIT_W, 2: max entries retired per cycle (1..4).
- WB_PORTS, 2: writeback ports.
- clk_in  in  1  clock; all logic on posedge.
- rst_in  in  1  synchronous, active-high reset.
- rdy_in  in  1  global enable; low freezes every register, outputs included.
- alloc_valid  in  1  decoder requests an entry.
- alloc_ready  out  1  entry available (count < depth and !flush).
- alloc_tag  out  ROB_WIDTH  tag granted (= tail).
- wb_valid  in  WB_PORTS  per-port result valid.
- wb_tag  in  WB_PORTS*ROB_WIDTH  packed tags.
- wb_op  in  WB_PORTS*3  op class (WRITE/JUMP/BOTH/LS/NOTHING).
- wb_rd  in  WB_PORTS*5  destination register.
- wb_wdata  in  WB_PORTS*32  result data.
- wb_jump  in  WB_PORTS*32  redirect target.
- wb_rs_index  in  WB_PORTS*RS_WIDTH  producing RS slot.
- commit_valid  out  COMMIT_W  per-lane retire pulse.
- commit_we  out  COMMIT_W  lane writes register file.
- commit_rd  out  COMMIT_W*5; commit_wdata  out  COMMIT_W*32.
- commit_rs_index  out  COMMIT_W*RS_WIDTH  RS slot to update.
- lsb_commit  out  1; lsb_tag  out  ROB_WIDTH  store release.
- flush  out  1  pipeline clear pulse; redirect_pc  out  32.
- occupancy  out  ROB_WIDTH+1  live entry count.

## Operation
- Reset: head=tail=count=0, all ready bits 0; every registered output 0; alloc_ready therefore 1.
- Alloc: fires on alloc_valid & alloc_ready; entry[tail].ready<=0, tail++ (wraps mod depth), count++.
- Writeback: per port, writes op/rd/wdata/jump/rs_index and sets ready. Tag outside [head,tail) ignored. Two ports same tag same cycle: lower port index wins.
- Commit select: scan lanes i=0..COMMIT_W-1 from head; lane i retires iff entries 0..i all allocated and ready (sampled at cycle start), and stop rules allow:
  - JUMP or BOTH retires then ends the group (no younger lane retires);
  - at most one LS per group; a second LS ends the group before it;
  - NOTHING retires with commit_we=0.
- Per retired lane: commit_valid=1, commit_we=1 for WRITE/BOTH, commit_rd/wdata/rs_index from entry. LS lane: lsb_commit=1, lsb_tag=its tag.
- head += n_retired, count += alloc - n_retired, same edge.
- Redirect: JUMP/BOTH retired -> flush=1, redirect_pc=jump next cycle. While flush=1: alloc_ready=0, writebacks ignored, no commit; at that edge head=tail=count=0, ready cleared, flush drops.
- rst_in wins over everything including pending flush.

## Timing
- Writeback -> earliest commit_valid: 2 edges (ready set at edge 1, commit registered at edge 2).
- Commit/lsb/flush outputs are registered one-cycle pulses; deassert the next enabled cycle.
- alloc_ready combinational from count and flush; alloc accepted same edge.
- Full (count=depth): alloc_ready=0; a same-cycle commit frees space visible next cycle only.
- Empty: no commit; alloc and commit of the same entry never in one cycle.
- Wrap-around of head/tail natural modulo 2**ROB_WIDTH; count disambiguates full vs empty.

## Structure
- Package rob_pkg: op encodings (WRITE=000, JUMP=001, BOTH=010, LS=011, NOTHING=100), helper width localparams.
- Sub-module rob_commit_select: combinational; inputs ready/op of COMMIT_W entries from head and count; outputs per-lane retire mask and n_retired.

## Test plan
- Reset, alloc 3, wb tags 2,0,1 (WRITE, rd 5,6,7) -> tags 0,1 retire together (COMMIT_W=2), tag 2 next cycle; rf writes rd 5,6,7 in order.
- Fill 16 entries -> alloc_ready=0, occupancy=16; retire 2 -> alloc_ready=1 the following cycle; tail wraps to 0,1.
- Tags 0 JUMP (jump=0x100), 1 WRITE both ready -> only tag 0 retires, flush=1, redirect_pc=0x100 next cycle, then occupancy=0, alloc_tag=0.
- Tags 0,1 both LS ready -> lsb_commit tag 0 one cycle, tag 1 next cycle.
- Both wb ports hit tag 3 same cycle with wdata 0xA/0xB -> committed wdata 0xA.
- rdy_in low 3 cycles mid-commit -> all outputs/state frozen; resumes identically; rst_in mid-flush -> all outputs 0.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared definitions for the multi-commit reorder buffer: op classes and payload widths.
package rob_pkg;

   typedef enum logic [2:0] {
      OP_WRITE   = 3'b000,
      OP_JUMP    = 3'b001,
      OP_BOTH    = 3'b010,
      OP_LS      = 3'b011,
      OP_NOTHING = 3'b100
   } rob_op_e;

   localparam int OP_W   = 3;
   localparam int RD_W   = 5;
   localparam int DATA_W = 32;

   function automatic logic op_redirects(input logic [OP_W-1:0] op);
      return (op == OP_JUMP) || (op == OP_BOTH);
   endfunction

   function automatic logic op_writes(input logic [OP_W-1:0] op);
      return (op == OP_WRITE) || (op == OP_BOTH);
   endfunction

endpackage

// File: rtl/rob_commit_select.sv
// Picks which of the oldest COMMIT_W entries retire this cycle, honouring the
// jump-ends-group and one-store-per-group rules.
module rob_commit_select
   import rob_pkg::*;
#(
   parameter int COMMIT_W = 2,
   parameter int CNT_W    = 5
) (
   input  logic [COMMIT_W-1:0]      lane_ready,
   input  logic [COMMIT_W*OP_W-1:0] lane_op,
   input  logic [CNT_W-1:0]         count,
   output logic [COMMIT_W-1:0]      retire_mask,
   output logic [2:0]               n_retired
);

   logic              stop_s;
   logic              ls_seen_s;
   logic [OP_W-1:0]   op_s;

   // In-order scan from head; the first blocked lane ends the group.
   always_comb begin
      retire_mask = {COMMIT_W{1'b0}};
      n_retired   = 3'd0;
      stop_s      = 1'b0;
      ls_seen_s   = 1'b0;
      op_s        = {OP_W{1'b0}};
      for (int i = 0; i < COMMIT_W; i++) begin
         op_s = lane_op[i*OP_W +: OP_W];
         if (!stop_s && (CNT_W'(i) < count) && lane_ready[i]) begin
            if ((op_s == OP_LS) && ls_seen_s) begin
               stop_s = 1'b1;
            end else begin
               retire_mask[i] = 1'b1;
               n_retired      = n_retired + 3'd1;
               if (op_redirects(op_s)) begin
                  stop_s = 1'b1;
               end else if (op_s == OP_LS) begin
                  ls_seen_s = 1'b1;
               end else begin
                  ls_seen_s = ls_seen_s;
               end
            end
         end else begin
            stop_s = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rob_mc.sv
// Multi-commit reorder buffer: in-order allocate, out-of-order writeback,
// in-order retire of up to COMMIT_W entries with store release and jump redirect.
module rob_mc
   import rob_pkg::*;
#(
   parameter int ROB_WIDTH = 4,
   parameter int RS_WIDTH  = 2,
   parameter int COMMIT_W  = 2,
   parameter int WB_PORTS  = 2
) (
   input  logic                           clk_in,
   input  logic                           rst_in,
   input  logic                           rdy_in,
   input  logic                           alloc_valid,
   output logic                           alloc_ready,
   output logic [ROB_WIDTH-1:0]           alloc_tag,
   input  logic [WB_PORTS-1:0]            wb_valid,
   input  logic [WB_PORTS*ROB_WIDTH-1:0]  wb_tag,
   input  logic [WB_PORTS*3-1:0]          wb_op,
   input  logic [WB_PORTS*5-1:0]          wb_rd,
   input  logic [WB_PORTS*32-1:0]         wb_wdata,
   input  logic [WB_PORTS*32-1:0]         wb_jump,
   input  logic [WB_PORTS*RS_WIDTH-1:0]   wb_rs_index,
   output logic [COMMIT_W-1:0]            commit_valid,
   output logic [COMMIT_W-1:0]            commit_we,
   output logic [COMMIT_W*5-1:0]          commit_rd,
   output logic [COMMIT_W*32-1:0]         commit_wdata,
   output logic [COMMIT_W*RS_WIDTH-1:0]   commit_rs_index,
   output logic                           lsb_commit,
   output logic [ROB_WIDTH-1:0]           lsb_tag,
   output logic                           flush,
   output logic [31:0]                    redirect_pc,
   output logic [ROB_WIDTH:0]             occupancy
);

   localparam int DEPTH = 2**ROB_WIDTH;
   localparam logic [ROB_WIDTH:0] DEPTH_C = (ROB_WIDTH+1)'(DEPTH);

   logic                 ready_r    [DEPTH];
   logic [OP_W-1:0]      op_r       [DEPTH];
   logic [RD_W-1:0]      rd_r       [DEPTH];
   logic [DATA_W-1:0]    wdata_r    [DEPTH];
   logic [DATA_W-1:0]    jump_r     [DEPTH];
   logic [RS_WIDTH-1:0]  rs_index_r [DEPTH];

   logic [ROB_WIDTH-1:0] head_r, tail_r;
   logic [ROB_WIDTH:0]   count_r;

   logic                 alloc_fire_s;
   logic [ROB_WIDTH-1:0] wb_tag_s   [WB_PORTS];
   logic [ROB_WIDTH-1:0] wb_off_s   [WB_PORTS];
   logic [WB_PORTS-1:0]  wb_hit_s;
   logic [ROB_WIDTH-1:0] lane_idx_s [COMMIT_W];
   logic [COMMIT_W-1:0]  lane_ready_s;
   logic [COMMIT_W*OP_W-1:0] lane_op_s;
   logic [COMMIT_W-1:0]  sel_mask_s, retire_s;
   logic [2:0]           sel_n_s, n_ret_s;
   logic                 ls_hit_s, jump_hit_s;
   logic [ROB_WIDTH-1:0] ls_tag_s;
   logic [31:0]          jump_pc_s;

   assign alloc_ready  = (count_r != DEPTH_C) && !flush;
   assign alloc_tag    = tail_r;
   assign occupancy    = count_r;
   assign alloc_fire_s = alloc_valid && alloc_ready;

   // Tag-range filter: a result only lands on an entry inside [head, tail).
   always_comb begin
      for (int p = 0; p < WB_PORTS; p++) begin
         wb_tag_s[p] = wb_tag[p*ROB_WIDTH +: ROB_WIDTH];
         wb_off_s[p] = wb_tag_s[p] - head_r;
         wb_hit_s[p] = wb_valid[p] && ({1'b0, wb_off_s[p]} < count_r);
      end
   end

   // Present the oldest COMMIT_W entries to the selector.
   always_comb begin
      lane_op_s = {(COMMIT_W*OP_W){1'b0}};
      for (int i = 0; i < COMMIT_W; i++) begin
         lane_idx_s[i]            = head_r + ROB_WIDTH'(i);
         lane_ready_s[i]          = ready_r[lane_idx_s[i]];
         lane_op_s[i*OP_W +: OP_W] = op_r[lane_idx_s[i]];
      end
   end

   rob_commit_select #(
      .COMMIT_W (COMMIT_W),
      .CNT_W    (ROB_WIDTH+1)
   ) u_select (
      .lane_ready  (lane_ready_s),
      .lane_op     (lane_op_s),
      .count       (count_r),
      .retire_mask (sel_mask_s),
      .n_retired   (sel_n_s)
   );

   // Nothing retires during the flush cycle; also extract store/jump side effects.
   always_comb begin
      retire_s   = flush ? {COMMIT_W{1'b0}} : sel_mask_s;
      n_ret_s    = flush ? 3'd0 : sel_n_s;
      ls_hit_s   = 1'b0;
      ls_tag_s   = {ROB_WIDTH{1'b0}};
      jump_hit_s = 1'b0;
      jump_pc_s  = 32'h0;
      for (int i = 0; i < COMMIT_W; i++) begin
         if (retire_s[i] && (op_r[lane_idx_s[i]] == OP_LS)) begin
            ls_hit_s = 1'b1;
            ls_tag_s = lane_idx_s[i];
         end else begin
            ls_hit_s = ls_hit_s;
         end
         if (retire_s[i] && op_redirects(op_r[lane_idx_s[i]])) begin
            jump_hit_s = 1'b1;
            jump_pc_s  = jump_r[lane_idx_s[i]];
         end else begin
            jump_hit_s = jump_hit_s;
         end
      end
   end

   // Payload capture; the lower-indexed port is applied last so it wins a collision.
   always_ff @(posedge clk_in) begin
      if (rdy_in && !rst_in && !flush) begin
         for (int p = WB_PORTS-1; p >= 0; p--) begin
            if (wb_hit_s[p]) begin
               op_r[wb_tag_s[p]]       <= wb_op[p*OP_W +: OP_W];
               rd_r[wb_tag_s[p]]       <= wb_rd[p*RD_W +: RD_W];
               wdata_r[wb_tag_s[p]]    <= wb_wdata[p*DATA_W +: DATA_W];
               jump_r[wb_tag_s[p]]     <= wb_jump[p*DATA_W +: DATA_W];
               rs_index_r[wb_tag_s[p]] <= wb_rs_index[p*RS_WIDTH +: RS_WIDTH];
            end
         end
      end
   end

   // Pointers, ready bits and registered retire/redirect outputs.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         head_r          <= {ROB_WIDTH{1'b0}};
         tail_r          <= {ROB_WIDTH{1'b0}};
         count_r         <= {(ROB_WIDTH+1){1'b0}};
         for (int e = 0; e < DEPTH; e++) ready_r[e] <= 1'b0;
         commit_valid    <= {COMMIT_W{1'b0}};
         commit_we       <= {COMMIT_W{1'b0}};
         commit_rd       <= {(COMMIT_W*RD_W){1'b0}};
         commit_wdata    <= {(COMMIT_W*DATA_W){1'b0}};
         commit_rs_index <= {(COMMIT_W*RS_WIDTH){1'b0}};
         lsb_commit      <= 1'b0;
         lsb_tag         <= {ROB_WIDTH{1'b0}};
         flush           <= 1'b0;
         redirect_pc     <= 32'h0;
      end else if (rdy_in) begin
         if (alloc_fire_s) ready_r[tail_r] <= 1'b0;
         for (int p = 0; p < WB_PORTS; p++) begin
            if (wb_hit_s[p] && !flush) ready_r[wb_tag_s[p]] <= 1'b1;
         end
         if (flush) begin
            head_r  <= {ROB_WIDTH{1'b0}};
            tail_r  <= {ROB_WIDTH{1'b0}};
            count_r <= {(ROB_WIDTH+1){1'b0}};
            for (int e = 0; e < DEPTH; e++) ready_r[e] <= 1'b0;
         end else begin
            head_r  <= head_r + ROB_WIDTH'(n_ret_s);
            tail_r  <= tail_r + ROB_WIDTH'(alloc_fire_s);
            count_r <= count_r + (ROB_WIDTH+1)'(alloc_fire_s) - (ROB_WIDTH+1)'(n_ret_s);
         end
         commit_valid <= retire_s;
         for (int i = 0; i < COMMIT_W; i++) begin
            commit_we[i] <= retire_s[i] && op_writes(op_r[lane_idx_s[i]]);
            commit_rd[i*RD_W +: RD_W] <= retire_s[i] ? rd_r[lane_idx_s[i]] : {RD_W{1'b0}};
            commit_wdata[i*DATA_W +: DATA_W] <=
               retire_s[i] ? wdata_r[lane_idx_s[i]] : {DATA_W{1'b0}};
            commit_rs_index[i*RS_WIDTH +: RS_WIDTH] <=
               retire_s[i] ? rs_index_r[lane_idx_s[i]] : {RS_WIDTH{1'b0}};
         end
         lsb_commit <= ls_hit_s;
         lsb_tag    <= ls_tag_s;
         flush      <= jump_hit_s;
         if (jump_hit_s) redirect_pc <= jump_pc_s;
      end
   end

endmodule

// File: tb/tb_rob_mc.sv
// Directed self-checking bench for rob_mc with hand-computed expectations.
module tb_rob_mc;
   import rob_pkg::*;

   localparam int RW = 4;
   localparam int SW = 2;
   localparam int CW = 2;
   localparam int WP = 2;

   logic             clk_in = 1'b0;
   logic             rst_in, rdy_in, alloc_valid;
   logic             alloc_ready;
   logic [RW-1:0]    alloc_tag;
   logic [WP-1:0]    wb_valid;
   logic [WP*RW-1:0] wb_tag;
   logic [WP*3-1:0]  wb_op;
   logic [WP*5-1:0]  wb_rd;
   logic [WP*32-1:0] wb_wdata, wb_jump;
   logic [WP*SW-1:0] wb_rs_index;
   logic [CW-1:0]    commit_valid, commit_we;
   logic [CW*5-1:0]  commit_rd;
   logic [CW*32-1:0] commit_wdata;
   logic [CW*SW-1:0] commit_rs_index;
   logic             lsb_commit, flush;
   logic [RW-1:0]    lsb_tag;
   logic [31:0]      redirect_pc;
   logic [RW:0]      occupancy;

   int errors = 0;
   int checks = 0;

   rob_mc #(.ROB_WIDTH(RW), .RS_WIDTH(SW), .COMMIT_W(CW), .WB_PORTS(WP)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
      .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_op(wb_op), .wb_rd(wb_rd),
      .wb_wdata(wb_wdata), .wb_jump(wb_jump), .wb_rs_index(wb_rs_index),
      .commit_valid(commit_valid), .commit_we(commit_we), .commit_rd(commit_rd),
      .commit_wdata(commit_wdata), .commit_rs_index(commit_rs_index),
      .lsb_commit(lsb_commit), .lsb_tag(lsb_tag),
      .flush(flush), .redirect_pc(redirect_pc), .occupancy(occupancy)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic wb_clear();
      wb_valid = '0; wb_tag = '0; wb_op = '0; wb_rd = '0;
      wb_wdata = '0; wb_jump = '0; wb_rs_index = '0;
   endtask

   task automatic wb_set(input int p, input logic [RW-1:0] tag, input logic [2:0] op,
                         input logic [4:0] rd, input logic [31:0] wdata,
                         input logic [31:0] jump, input logic [SW-1:0] rs);
      wb_valid[p]            = 1'b1;
      wb_tag[p*RW +: RW]     = tag;
      wb_op[p*3 +: 3]        = op;
      wb_rd[p*5 +: 5]        = rd;
      wb_wdata[p*32 +: 32]   = wdata;
      wb_jump[p*32 +: 32]    = jump;
      wb_rs_index[p*SW +: SW] = rs;
   endtask

   task automatic do_reset();
      rst_in = 1'b1; alloc_valid = 1'b0; wb_clear();
      step(); step();
      rst_in = 1'b0;
   endtask

   task automatic alloc_n(input int n);
      alloc_valid = 1'b1;
      for (int k = 0; k < n; k++) step();
      alloc_valid = 1'b0;
   endtask

   initial begin
      rdy_in = 1'b1;
      do_reset();
      chk("rst_alloc_ready", alloc_ready, 1);
      chk("rst_occupancy", occupancy, 0);
      chk("rst_alloc_tag", alloc_tag, 0);
      chk("rst_commit_valid", commit_valid, 0);
      chk("rst_flush", flush, 0);

      // Out-of-order writeback, in-order dual retire
      alloc_n(3);
      chk("t1_occ3", occupancy, 3);
      wb_set(0, 4'd2, OP_WRITE, 5'd7, 32'h77, 32'h0, 2'd2); step(); wb_clear();
      wb_set(0, 4'd0, OP_WRITE, 5'd5, 32'h55, 32'h0, 2'd0);
      wb_set(1, 4'd1, OP_WRITE, 5'd6, 32'h66, 32'h0, 2'd1); step(); wb_clear();
      chk("t1_no_commit_yet", commit_valid, 0);
      step();
      chk("t1_cv_pair", commit_valid, 2'b11);
      chk("t1_we_pair", commit_we, 2'b11);
      chk("t1_rd_pair", commit_rd, {5'd6, 5'd5});
      chk("t1_wdata_l0", commit_wdata[31:0], 32'h55);
      chk("t1_wdata_l1", commit_wdata[63:32], 32'h66);
      chk("t1_occ1", occupancy, 1);
      step();
      chk("t1_cv_single", commit_valid, 2'b01);
      chk("t1_rd_single", commit_rd[4:0], 5'd7);
      chk("t1_rs_single", commit_rs_index[1:0], 2'd2);
      chk("t1_occ0", occupancy, 0);
      step();
      chk("t1_cv_idle", commit_valid, 0);

      // Full buffer, retire frees space next cycle, tail wraps
      do_reset();
      alloc_n(16);
      chk("t2_full_ready", alloc_ready, 0);
      chk("t2_full_occ", occupancy, 16);
      chk("t2_tail_wrap", alloc_tag, 0);
      wb_set(0, 4'd0, OP_WRITE, 5'd1, 32'h1, 32'h0, 2'd0);
      wb_set(1, 4'd1, OP_WRITE, 5'd2, 32'h2, 32'h0, 2'd1); step(); wb_clear();
      chk("t2_still_full", alloc_ready, 0);
      step();
      chk("t2_cv", commit_valid, 2'b11);
      chk("t2_ready_after", alloc_ready, 1);
      chk("t2_occ14", occupancy, 14);
      alloc_valid = 1'b1;
      chk("t2_tag0", alloc_tag, 0);
      step();
      chk("t2_tag1", alloc_tag, 1);
      step(); alloc_valid = 1'b0;
      chk("t2_refull", alloc_ready, 0);

      // Jump retires alone, flush then empty
      do_reset();
      alloc_n(2);
      wb_set(0, 4'd0, OP_JUMP, 5'd0, 32'h0, 32'h100, 2'd0);
      wb_set(1, 4'd1, OP_WRITE, 5'd3, 32'h33, 32'h0, 2'd1); step(); wb_clear();
      step();
      chk("t3_cv", commit_valid, 2'b01);
      chk("t3_we", commit_we, 2'b00);
      chk("t3_flush", flush, 1);
      chk("t3_pc", redirect_pc, 32'h100);
      chk("t3_flush_ready", alloc_ready, 0);
      step();
      chk("t3_flush_drop", flush, 0);
      chk("t3_occ0", occupancy, 0);
      chk("t3_tag0", alloc_tag, 0);
      chk("t3_cv_idle", commit_valid, 0);

      // Two stores retire in separate cycles
      alloc_n(2);
      wb_set(0, 4'd0, OP_LS, 5'd0, 32'h0, 32'h0, 2'd0);
      wb_set(1, 4'd1, OP_LS, 5'd0, 32'h0, 32'h0, 2'd1); step(); wb_clear();
      step();
      chk("t4_lsb0", lsb_commit, 1);
      chk("t4_lsb0_tag", lsb_tag, 0);
      chk("t4_cv0", commit_valid, 2'b01);
      step();
      chk("t4_lsb1", lsb_commit, 1);
      chk("t4_lsb1_tag", lsb_tag, 1);
      step();
      chk("t4_lsb_idle", lsb_commit, 0);
      chk("t4_occ0", occupancy, 0);

      // Same-tag collision: port 0 wins
      do_reset();
      alloc_n(4);
      wb_set(0, 4'd0, OP_WRITE, 5'd1, 32'h1, 32'h0, 2'd0);
      wb_set(1, 4'd1, OP_WRITE, 5'd2, 32'h2, 32'h0, 2'd0); step(); wb_clear();
      wb_set(0, 4'd2, OP_WRITE, 5'd3, 32'h3, 32'h0, 2'd0); step(); wb_clear();
      wb_set(0, 4'd3, OP_WRITE, 5'd4, 32'hA, 32'h0, 2'd0);
      wb_set(1, 4'd3, OP_WRITE, 5'd9, 32'hB, 32'h0, 2'd3); step(); wb_clear();
      step();
      chk("t5_cv", commit_valid, 2'b01);
      chk("t5_wdata", commit_wdata[31:0], 32'hA);
      chk("t5_rd", commit_rd[4:0], 5'd4);

      // Freeze with rdy_in low mid-commit, then resume
      do_reset();
      alloc_n(4);
      wb_set(0, 4'd0, OP_WRITE, 5'd10, 32'h10, 32'h0, 2'd0);
      wb_set(1, 4'd1, OP_WRITE, 5'd11, 32'h11, 32'h0, 2'd1); step(); wb_clear();
      wb_set(0, 4'd2, OP_WRITE, 5'd12, 32'h12, 32'h0, 2'd2);
      wb_set(1, 4'd3, OP_WRITE, 5'd13, 32'h13, 32'h0, 2'd3); step(); wb_clear();
      chk("t6_cv_pre", commit_valid, 2'b11);
      rdy_in = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("t6_frz_cv", commit_valid, 2'b11);
         chk("t6_frz_rd", commit_rd, {5'd11, 5'd10});
         chk("t6_frz_occ", occupancy, 2);
      end
      rdy_in = 1'b1;
      step();
      chk("t6_res_cv", commit_valid, 2'b11);
      chk("t6_res_rd", commit_rd, {5'd13, 5'd12});
      chk("t6_res_occ", occupancy, 0);

      // Reset during a pending flush
      alloc_n(1);
      wb_set(0, 4'd4, OP_BOTH, 5'd1, 32'h5, 32'h200, 2'd0); step(); wb_clear();
      step();
      chk("t7_flush", flush, 1);
      chk("t7_we_both", commit_we, 2'b01);
      rst_in = 1'b1; step(); rst_in = 1'b0;
      chk("t7_rst_flush", flush, 0);
      chk("t7_rst_cv", commit_valid, 0);
      chk("t7_rst_pc", redirect_pc, 0);
      chk("t7_rst_occ", occupancy, 0);
      chk("t7_rst_tag", alloc_tag, 0);
      chk("t7_rst_lsb", lsb_commit, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
